boot_rom_bridge: RTL and testbench
==================================

// Module: boot_rom_bridge
// PURPOSE
//  Bridges the core instruction-fetch port (req/gnt/rvalid, with response backpressure) to the
//  single-cycle synchronous boot ROM (CSN/A/Q, Q valid the cycle after CSN low).
//  Decodes the boot window, issues ROM reads and buffers responses in a small FIFO,
//  so a stalled fetch unit never loses an instruction word.
// PARAMETERS
//  BASE_ADDR   32'h0000_8000  byte address of ROM word 0
//  ROM_WORDS   16             implemented ROM words (window = ROM_WORDS*4 bytes)
//  ROM_AW      10             ROM word-address width
//  RESP_DEPTH  2              response FIFO entries (>=2, power of two)
// PORTS
//  CLK        in   1       clock, all state on rising edge
//  RST        in   1       synchronous reset, active-high
//  req_i      in   1       fetch request
//  addr_i     in   32      byte address, bits[1:0] ignored
//  gnt_o      out  1       request accepted this cycle
//  rvalid_o   out  1       response valid
//  rready_i   in   1       fetch unit accepts response
//  rdata_o    out  32      instruction word
//  err_o      out  1       response is a bus error (0 unless BOOT_ROM_BUSERR_EN)
//  rom_csn_o  out  1       ROM chip select, active-low
//  rom_a_o    out  ROM_AW  ROM word address
//  rom_q_i    in   32      ROM data, valid cycle after rom_csn_o low
// BEHAVIOUR
//  - Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, rom_csn_o=1, FIFO empty, inflight=0.
//  - offs = addr_i - BASE_ADDR; rom_a_o = offs[ROM_AW+1:2] (driven combinationally always).
//  - gnt_o = req_i & (count + inflight < RESP_DEPTH); a pop in the same cycle does not free a slot.
//  - rom_csn_o = ~(gnt_o & in_range); no ROM access for out-of-range grants.
//  - Granted at cycle N -> inflight=1 in N+1, with captured err flag (out-of-range & BUSERR_EN).
//  - Cycle N+1: response = {rom_q_i, 0} or {32'h0, 1} for error.
//  - FWFT bypass: if FIFO empty at N+1, rvalid_o=1 and response driven directly (latency 1).
//    If rready_i=1 it is consumed; otherwise it is written to FIFO.
//  - FIFO non-empty: rvalid_o=1, outputs show the head entry; in-flight response pushes to tail.
//    Responses are never reordered.
//  - rvalid_o & ~rready_i: rdata_o/err_o held stable until accepted.
//  - Back-to-back grants allowed: with rready_i=1 continuously, throughput is 1 word/cycle.
//  - Push and pop in the same cycle: count unchanged; full FIFO is prevented by gnt accounting,
//    so a push to a full FIFO is an assertion failure.
//  - rdata_o/err_o are 0 whenever rvalid_o=0.
//  - Reset mid-transfer: inflight response and FIFO contents are discarded; no rvalid after reset.
// CONFIGURATION
//  BOOT_ROM_BUSERR_EN defined:
//    - in_range = offs < ROM_WORDS*4.
//    - Out-of-range requests are granted with rom_csn_o=1.
//    - Response rdata=0, err=1 with the same timing.
//  BOOT_ROM_BUSERR_EN undefined:
//    - in_range = 1; addresses alias modulo 2^(ROM_AW+2).
//    - err_o tied 0; err bit removed from the FIFO.
// STRUCTURE
//  - Package boot_rom_pkg:
//    - BOOT_ROM_BASE (32'h0000_8000)
//    - BOOT_NOP (32'h0000_0013)
//    - typedef struct packed {logic [31:0] data; logic err;} boot_resp_t
//  - Sub-module boot_resp_fifo:
//    - RESP_DEPTH-entry synchronous FIFO of boot_resp_t.
//    - Ports: push, pop, full, empty, count, head.
//  - Top level: address decode, gnt accounting, inflight register, FWFT bypass mux.
// TESTING
//  1. Reset, req_i=1 addr=32'h8000 -> gnt N, rom_a_o=0, csn low N;
//     rvalid N+1, rdata=ROM[0]=32'h00000013.
//  2. 4 back-to-back req 32'h8000..800C, rready=1 -> 4 gnts, 4 rvalid in consecutive cycles,
//     in order, 32'h00000013.
//  3. rready=0 with req held -> exactly 2 gnts then gnt=0; rdata stable;
//     rready=1 drains both in order, gnt resumes.
//  4. BUSERR_EN, addr=32'h8040 (ROM_WORDS=16) -> gnt=1, csn stays 1;
//     N+1 rvalid=1, err=1, rdata=0.
//  5. RST asserted while inflight=1 and FIFO holds 1 -> next cycle rvalid=0, csn=1, count=0.
//  6. Without BUSERR_EN, addr=32'h8000+4*1024 -> rom_a_o=0, err=0, rdata=ROM[0].

Source files
------------

// File: rtl/boot_rom_pkg.sv
// Shared types and constants for the boot ROM fetch bridge.
// Optional build macro: BOOT_ROM_BUSERR_EN (out-of-window fetches return a bus error).
package boot_rom_pkg;

  localparam logic [31:0] BOOT_ROM_BASE = 32'h0000_8000;
  localparam logic [31:0] BOOT_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } boot_resp_t;

  // An error response carries no data so a faulting fetch never leaks ROM contents.
  function automatic boot_resp_t mk_resp(input logic [31:0] q, input logic err);
    boot_resp_t r;
    r.data = err ? 32'h0 : q;
    r.err  = err;
    return r;
  endfunction

endpackage

// File: rtl/boot_resp_fifo.sv
// Response FIFO for the boot ROM bridge: DEPTH entries of boot_resp_t.
// Optional build macro: BOOT_ROM_BUSERR_EN (when undefined the err bit is not stored).
import boot_rom_pkg::*;

module boot_resp_fifo #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  boot_resp_t    wdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output boot_resp_t    head
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

`ifdef BOOT_ROM_BUSERR_EN
  boot_resp_t mem [DEPTH];

  // storage: data only, no reset
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];
`else
  logic [31:0] mem [DEPTH];
  logic        unused_err;

  // storage: data only, no reset
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata.data;
  end

  assign unused_err = wdata.err;
  assign head       = '{data: mem[rd_ptr], err: 1'b0};
`endif

  // pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // grant accounting upstream must make overflow and underflow impossible
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/boot_rom_bridge.sv
// Bridges the fetch port (req/gnt/rvalid with backpressure) to a single-cycle
// synchronous boot ROM; responses are buffered so a stalled fetch loses nothing.
// Optional build macro: BOOT_ROM_BUSERR_EN (window check, error responses).
import boot_rom_pkg::*;

module boot_rom_bridge #(
  parameter logic [31:0] BASE_ADDR  = BOOT_ROM_BASE,
  parameter int          ROM_WORDS  = 16,
  parameter int          ROM_AW     = 10,
  parameter int          RESP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_i,
  input  logic [31:0]       addr_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic [31:0]   offs;
  logic          in_range;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          vld_p1;
  boot_resp_t    resp_p1;
  boot_resp_t    head;
  boot_resp_t    out_resp;

  // ---- stage p0: decode and grant ----
  assign offs    = addr_i - BASE_ADDR;
  assign rom_a_o = offs[ROM_AW+1:2];

`ifdef BOOT_ROM_BUSERR_EN
  logic unused_cfg;
  assign in_range   = (offs < 32'(ROM_WORDS * 4));
  assign unused_cfg = fifo_full;
`else
  logic unused_cfg;
  assign in_range   = 1'b1;
  assign unused_cfg = ^{offs[31:ROM_AW+2], offs[1:0], fifo_full, 32'(ROM_WORDS)};
`endif

  // A pop in the current cycle deliberately does not free a slot for this grant.
  assign occ       = fifo_count + CW'(vld_p1);
  assign gnt_o     = req_i & ~RST & (occ < CW'(RESP_DEPTH));
  assign rom_csn_o = ~(gnt_o & in_range);

  // ---- stage p1: ROM data returns, bypass or buffer ----
  always_ff @(posedge CLK) begin
    if (RST) vld_p1 <= 1'b0;
    else     vld_p1 <= gnt_o;
  end

`ifdef BOOT_ROM_BUSERR_EN
  logic err_p1;

  always_ff @(posedge CLK) begin
    if (gnt_o) err_p1 <= ~in_range;
  end

  assign resp_p1 = mk_resp(rom_q_i, err_p1);
`else
  assign resp_p1 = mk_resp(rom_q_i, 1'b0);
`endif

  assign push = vld_p1 & ~(fifo_empty & rready_i);
  assign pop  = ~fifo_empty & rready_i;

  boot_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (resp_p1),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  assign out_resp = fifo_empty ? resp_p1 : head;
  assign rvalid_o = vld_p1 | ~fifo_empty;
  assign rdata_o  = rvalid_o ? out_resp.data : 32'h0;

`ifdef BOOT_ROM_BUSERR_EN
  assign err_o = rvalid_o & out_resp.err;
`else
  logic unused_out_err;
  assign unused_out_err = out_resp.err;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_boot_rom_bridge.sv
// Directed testbench for boot_rom_bridge with a behavioural synchronous ROM.
// Honours BOOT_ROM_BUSERR_EN for the out-of-window scenario.
module tb_boot_rom_bridge;
  import boot_rom_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_i;
  logic [31:0] addr_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        rom_csn_o;
  logic [9:0]  rom_a_o;
  logic [31:0] rom_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  boot_rom_bridge dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .rom_csn_o (rom_csn_o),
    .rom_a_o   (rom_a_o),
    .rom_q_i   (rom_q)
  );

  // Word 0 is the NOP; other words are distinct so ordering errors show up.
  function automatic logic [31:0] rom_word(input int i);
    return (i == 0) ? BOOT_NOP : (32'hC0DE_0000 | 32'(i));
  endfunction

  // single-cycle synchronous ROM, Q held while deselected
  always @(posedge CLK) begin
    if (!rom_csn_o) rom_q <= rom_word(int'(rom_a_o[3:0]));
  end

  // Drive one cycle's inputs at the falling edge, then settle before checks.
  task automatic step(input logic rst, input logic req, input logic [31:0] addr, input logic rdy);
    @(negedge CLK);
    RST = rst; req_i = req; addr_i = addr; rready_i = rdy;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 32'h8000, 1'b1);
    n_tests++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0", gnt_o); end
    step(1'b1, 1'b0, 32'h8000, 1'b1);
    step(1'b0, 1'b0, 32'h8000, 1'b1);
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
    n_tests++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
    n_tests++; if (rom_csn_o !== 1'b1) begin n_fail++; $display("FAIL reset_csn got %b want 1", rom_csn_o); end
  endtask

  task automatic test_single();
    step(1'b0, 1'b1, 32'h8000, 1'b1);
    n_tests++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL single_gnt got %b want 1", gnt_o); end
    n_tests++; if (rom_a_o !== 10'd0) begin n_fail++; $display("FAIL single_a got %0d want 0", rom_a_o); end
    n_tests++; if (rom_csn_o !== 1'b0) begin n_fail++; $display("FAIL single_csn got %b want 0", rom_csn_o); end
    step(1'b0, 1'b0, 32'h8000, 1'b1);
    n_tests++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_rvalid got %b want 1", rvalid_o); end
    n_tests++; if (rdata_o !== 32'h0000_0013) begin n_fail++; $display("FAIL single_rdata got %h want 00000013", rdata_o); end
    step(1'b0, 1'b0, 32'h8000, 1'b1);
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", rvalid_o); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, c < 4, 32'h8000 + 32'(4 * c), 1'b1);
      if (c < 4) begin
        n_tests++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d got %b want 1", c, gnt_o); end
        n_tests++; if (rom_a_o !== 10'(c)) begin n_fail++; $display("FAIL b2b_a%0d got %0d want %0d", c, rom_a_o, c); end
      end
      if (c > 0) begin
        n_tests++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid%0d got %b want 1", c, rvalid_o); end
        n_tests++; if (rdata_o !== rom_word(c - 1)) begin n_fail++; $display("FAIL b2b_rdata%0d got %h want %h", c, rdata_o, rom_word(c - 1)); end
      end
    end
    step(1'b0, 1'b0, 32'h8000, 1'b1);
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", rvalid_o); end
  endtask

  task automatic test_backpressure();
    logic        exp_gnt [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        exp_vld [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_dat [8];
    logic [31:0] addr    [8] = '{32'h8000, 32'h8004, 32'h8008, 32'h8008, 32'h8008, 32'h8008, 32'h8008, 32'h8008};
    logic        req     [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        rdy     [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_dat = '{32'h0, rom_word(0), rom_word(0), rom_word(0), rom_word(0), rom_word(1), rom_word(2), 32'h0};
    for (int c = 0; c < 8; c++) begin
      step(1'b0, req[c], addr[c], rdy[c]);
      n_tests++; if (gnt_o !== exp_gnt[c]) begin n_fail++; $display("FAIL bp_gnt%0d got %b want %b", c, gnt_o, exp_gnt[c]); end
      n_tests++; if (rvalid_o !== exp_vld[c]) begin n_fail++; $display("FAIL bp_rvalid%0d got %b want %b", c, rvalid_o, exp_vld[c]); end
      n_tests++; if (rdata_o !== exp_dat[c]) begin n_fail++; $display("FAIL bp_rdata%0d got %h want %h", c, rdata_o, exp_dat[c]); end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 32'h8000, 1'b0);
    step(1'b0, 1'b1, 32'h8004, 1'b0);
    n_tests++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b want 1", rvalid_o); end
    step(1'b1, 1'b1, 32'h8008, 1'b0);
    n_tests++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_gnt got %b want 0", gnt_o); end
    step(1'b0, 1'b0, 32'h8008, 1'b1);
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid got %b want 0", rvalid_o); end
    n_tests++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata got %h want 0", rdata_o); end
    n_tests++; if (rom_csn_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_csn got %b want 1", rom_csn_o); end
    step(1'b0, 1'b1, 32'h800C, 1'b1);
    n_tests++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_regnt got %b want 1", gnt_o); end
    step(1'b0, 1'b0, 32'h800C, 1'b1);
    n_tests++; if (rdata_o !== rom_word(3)) begin n_fail++; $display("FAIL rstmid_rdata3 got %h want %h", rdata_o, rom_word(3)); end
    step(1'b0, 1'b0, 32'h800C, 1'b1);
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got %b want 0", rvalid_o); end
  endtask

`ifdef BOOT_ROM_BUSERR_EN
  task automatic test_window();
    step(1'b0, 1'b1, 32'h8040, 1'b1);
    n_tests++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL buserr_gnt got %b want 1", gnt_o); end
    n_tests++; if (rom_csn_o !== 1'b1) begin n_fail++; $display("FAIL buserr_csn got %b want 1", rom_csn_o); end
    step(1'b0, 1'b0, 32'h8000, 1'b1);
    n_tests++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL buserr_rvalid got %b want 1", rvalid_o); end
    n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL buserr_err got %b want 1", err_o); end
    n_tests++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL buserr_rdata got %h want 0", rdata_o); end
    step(1'b0, 1'b0, 32'h8000, 1'b1);
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL buserr_idle got %b want 0", err_o); end
  endtask
`else
  task automatic test_window();
    step(1'b0, 1'b1, 32'h8000 + 32'd4096, 1'b1);
    n_tests++; if (rom_a_o !== 10'd0) begin n_fail++; $display("FAIL alias_a got %0d want 0", rom_a_o); end
    n_tests++; if (rom_csn_o !== 1'b0) begin n_fail++; $display("FAIL alias_csn got %b want 0", rom_csn_o); end
    step(1'b0, 1'b1, 32'h8040, 1'b1);
    n_tests++; if (rdata_o !== rom_word(0)) begin n_fail++; $display("FAIL alias_rdata got %h want %h", rdata_o, rom_word(0)); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL alias_err got %b want 0", err_o); end
    n_tests++; if (rom_a_o !== 10'd16) begin n_fail++; $display("FAIL alias_a16 got %0d want 16", rom_a_o); end
    step(1'b0, 1'b0, 32'h8000, 1'b1);
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL alias_err16 got %b want 0", err_o); end
  endtask
`endif

  initial begin
    RST = 1'b1; req_i = 1'b0; addr_i = 32'h0; rready_i = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_window();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
